// File: rtl/spirx_word.sv
// spirx_word: 24-bit SPI receive slave with valid/ack holding register, framing and overrun faults.
// Optional SPIRX_MISO_EN adds the reply port and MISO transmit shifter.
module spirx_word (
    input  logic        clk,
    input  logic        rst,
    input  logic        CS,
    input  logic        SCL,
    input  logic        MOSI,
    input  logic        ack,
`ifdef SPIRX_MISO_EN
    input  logic [23:0] reply,
    output logic        MISO,
`endif
    output logic [23:0] rx,
    output logic        valid,
    output logic        busy,
    output logic        ferr,
    output logic        ovr
);
    typedef enum logic [1:0] {WAIT, IDLE, SHIFT, DONE} state_t;
    state_t      state, state_n;
    logic [1:0]  cs_m, scl_m, mosi_m;
    logic        cs_h, scl_h;
    logic [4:0]  cnt, cnt_n;
    logic [23:0] sr, sr_n;
    logic        extra, extra_n, ferr_n, done;
    logic        cs_fall, cs_rise, scl_rise, scl_fall;
    // CS synchronizer resets low so a frame cut by rst is not re-entered mid-word
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_m   <= 2'b00;
            cs_h   <= 1'b0;
            scl_m  <= 2'b11;
            scl_h  <= 1'b1;
            mosi_m <= 2'b00;
        end else begin
            cs_m   <= {cs_m[0], CS};
            cs_h   <= cs_m[1];
            scl_m  <= {scl_m[0], SCL};
            scl_h  <= scl_m[1];
            mosi_m <= {mosi_m[0], MOSI};
        end
    end
    assign cs_fall  = cs_h & ~cs_m[1];
    assign cs_rise  = ~cs_h & cs_m[1];
    assign scl_rise = ~scl_h & scl_m[1];
    assign scl_fall = scl_h & ~scl_m[1];
    assign busy     = (state == SHIFT) || (state == DONE);
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        extra_n = extra;
        ferr_n  = 1'b0;
        done    = 1'b0;
        case (state)
            WAIT: if (cs_m[1]) state_n = IDLE;
            IDLE: if (cs_fall) begin
                state_n = SHIFT;
                cnt_n   = 5'd0;
                sr_n    = 24'd0;
                extra_n = 1'b0;
            end
            SHIFT: if (cs_rise) begin
                state_n = IDLE;
                ferr_n  = cnt != 5'd0;
            end else if (scl_rise) begin
                sr_n  = {sr[22:0], mosi_m[1]};
                cnt_n = cnt + 5'd1;
                if (cnt == 5'd23) begin
                    state_n = DONE;
                    done    = 1'b1;
                end
            end
            DONE: if (cs_rise) begin
                state_n = IDLE;
                ferr_n  = extra;
            end else if (scl_rise) extra_n = 1'b1;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT;
            cnt   <= 5'd0;
            sr    <= 24'd0;
            extra <= 1'b0;
            rx    <= 24'd0;
            valid <= 1'b0;
            ferr  <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sr    <= sr_n;
            extra <= extra_n;
            ferr  <= ferr_n;
            ovr   <= done & valid & ~ack;
            if (done & (~valid | ack)) begin
                rx    <= sr_n;
                valid <= 1'b1;
            end else if (ack) valid <= 1'b0;
        end
    end
`ifdef SPIRX_MISO_EN
    logic [23:0] tx;
    // the first SCL fall presents bit 23 already loaded at CS fall, so shifting starts after bit 0 is sampled
    always_ff @(posedge clk) begin
        if (rst) tx <= 24'd0;
        else if (state == IDLE && cs_fall) tx <= reply;
        else if (state == SHIFT && scl_fall && cnt != 5'd0) tx <= {tx[22:0], 1'b0};
    end
    assign MISO = (state == SHIFT) & tx[23];
`endif
endmodule

// File: tb/tb_spirx_word.sv
// tb_spirx_word: vector table plus scoreboard bench for spirx_word.
module tb_spirx_word;
    logic        clk = 0, rst = 1, CS = 1, SCL = 1, MOSI = 0, ack = 0;
    logic [23:0] rx;
    logic        valid, busy, ferr, ovr;
`ifdef SPIRX_MISO_EN
    logic [23:0] reply = 0, miso_cap = 0;
    logic        miso;
`endif
    int checks = 0, failures = 0, nferr = 0, novr = 0;
    logic [23:0] sb[$];
    logic        pv = 0;
    logic [23:0] prx = 0;

    spirx_word dut (
        .clk(clk), .rst(rst), .CS(CS), .SCL(SCL), .MOSI(MOSI), .ack(ack),
`ifdef SPIRX_MISO_EN
        .reply(reply), .MISO(miso),
`endif
        .rx(rx), .valid(valid), .busy(busy), .ferr(ferr), .ovr(ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] w;
        int          n;
        int          mode;
        bit          push;
        bit          ack_after;
        int          eferr;
        int          eovr;
        logic [23:0] erx;
        bit          evalid;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (ferr) nferr++;
        if (ovr) novr++;
    end

    always @(negedge clk) begin
        if (!rst && valid && (!pv || rx != prx)) begin
            if (sb.size() == 0) chk("sb_unexpected_word", {8'd0, rx}, 32'hFFFFFFFF);
            else chk("sb_word", {8'd0, rx}, {8'd0, sb.pop_front()});
        end
        pv  = valid;
        prx = rx;
    end

    // mode 1: ack lands in the completion cycle; mode 2: checks valid latency
    task automatic edge_probe(input int mode);
        @(posedge clk);
        @(posedge clk);
        #1;
        if (mode == 1) ack = 1;
        else chk("valid_before_edge", {31'd0, valid}, 0);
        @(posedge clk);
        #1;
        if (mode == 1) ack = 0;
        else chk("valid_latency", {31'd0, valid}, 1);
    endtask

    task automatic clk_bits(input logic [23:0] w, input int lo, input int hi, input int mode);
        for (int i = lo; i < hi; i++) begin
            SCL  = 0;
            MOSI = (i < 24) ? w[23 - i] : 1'b1;
            repeat (4) @(negedge clk);
            SCL = 1;
`ifdef SPIRX_MISO_EN
            if (i < 24) miso_cap[23 - i] = miso;
`endif
            if (i == 23 && mode != 0) fork edge_probe(mode); join_none
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send(input logic [23:0] w, input int n, input int mode);
        @(negedge clk);
        CS = 0;
        repeat (4) @(negedge clk);
        clk_bits(w, 0, n, mode);
        CS = 1;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1;
        @(negedge clk);
        ack = 0;
        chk("ack_clears_valid", {31'd0, valid}, 0);
    endtask

    initial begin
        vec_t vecs[8];
        int   bf, bo;
        vecs[0] = '{24'hA5C3F0, 24, 2, 1, 1, 0, 0, 24'hA5C3F0, 1};
        vecs[1] = '{24'h000001, 24, 0, 1, 0, 0, 0, 24'h000001, 1};
        vecs[2] = '{24'hFFFFFE, 24, 0, 0, 1, 0, 1, 24'h000001, 1};
        vecs[3] = '{24'h000001, 24, 0, 1, 0, 0, 0, 24'h000001, 1};
        vecs[4] = '{24'hFFFFFE, 24, 1, 1, 1, 0, 0, 24'hFFFFFE, 1};
        vecs[5] = '{24'h3FF000, 10, 0, 0, 0, 1, 0, 24'hFFFFFE, 0};
        vecs[6] = '{24'h123456, 24, 0, 1, 1, 0, 0, 24'h123456, 1};
        vecs[7] = '{24'hABCDEF, 25, 0, 1, 1, 1, 0, 24'hABCDEF, 1};

        repeat (3) @(negedge clk);
        chk("reset_rx", {8'd0, rx}, 0);
        chk("reset_valid", {31'd0, valid}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_ferr", {31'd0, ferr}, 0);
        chk("reset_ovr", {31'd0, ovr}, 0);
        rst = 0;
        repeat (6) @(negedge clk);

        foreach (vecs[k]) begin
            bf = nferr;
            bo = novr;
            if (vecs[k].push) sb.push_back(vecs[k].w);
            send(vecs[k].w, vecs[k].n, vecs[k].mode);
            chk($sformatf("v%0d_rx", k), {8'd0, rx}, {8'd0, vecs[k].erx});
            chk($sformatf("v%0d_valid", k), {31'd0, valid}, {31'd0, vecs[k].evalid});
            chk($sformatf("v%0d_ferr", k), nferr - bf, vecs[k].eferr);
            chk($sformatf("v%0d_ovr", k), novr - bo, vecs[k].eovr);
            chk($sformatf("v%0d_busy", k), {31'd0, busy}, 0);
            if (vecs[k].ack_after) do_ack();
        end

        bf = nferr;
        @(negedge clk);
        CS = 0;
        repeat (4) @(negedge clk);
        clk_bits(24'hFFFFFF, 0, 12, 0);
        chk("busy_mid_frame", {31'd0, busy}, 1);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_mid_rx", {8'd0, rx}, 0);
        chk("rst_mid_busy", {31'd0, busy}, 0);
        clk_bits(24'hFFFFFF, 12, 24, 0);
        CS = 1;
        repeat (8) @(negedge clk);
        chk("rst_frame_valid", {31'd0, valid}, 0);
        chk("rst_frame_ferr", nferr - bf, 0);
        sb.push_back(24'h5A5A5A);
        send(24'h5A5A5A, 24, 0);
        chk("post_rst_rx", {8'd0, rx}, 24'h5A5A5A);
        chk("post_rst_valid", {31'd0, valid}, 1);
        do_ack();

`ifdef SPIRX_MISO_EN
        reply = 24'h123456;
        sb.push_back(24'h000000);
        send(24'h000000, 24, 0);
        chk("miso_word", {8'd0, miso_cap}, 24'h123456);
        chk("miso_idle", {31'd0, miso}, 0);
        do_ack();
`endif

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
